// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Summary  : Bank of runtime-programmable clock-enable / square-wave dividers.
//            Each channel counts enabled cycles up to a half-period H and
//            then toggles its level and emits a one-cycle tick. Channels run
//            either periodically or as a one-shot that freezes when done.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module clk_div_bank #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 28,
   parameter int DEFAULT_HALF = 50000000,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_half,
   input  logic              cfg_oneshot,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] done
);

   localparam logic [CNT_W-1:0] C_DEF_HALF = CNT_W'(DEFAULT_HALF);

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         logic [CNT_W-1:0] half_q;
         logic [CNT_W-1:0] cnt_q;
         logic             oneshot_q;
         logic             level_q;
         logic             tick_q;
         logic             done_q;
         logic             wr_hit;
         logic             term;

         // A channel index outside 0..NUM_CH-1 never matches, so such
         // writes fall through without touching any channel.
         assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));
         // Increments stop at H, so equality is the only terminal test needed.
         assign term   = en[i] && (cnt_q == half_q) && !done_q;

         // Per-channel divider state with reset > write > sync > terminal > count.
         always_ff @(posedge clk) begin
            if (reset) begin
               half_q    <= C_DEF_HALF;
               oneshot_q <= 1'b0;
               cnt_q     <= '0;
               level_q   <= 1'b0;
               tick_q    <= 1'b0;
               done_q    <= 1'b0;
            end else if (wr_hit) begin
               half_q    <= cfg_half;
               oneshot_q <= cfg_oneshot;
               cnt_q     <= '0;
               level_q   <= 1'b0;
               tick_q    <= 1'b0;
               done_q    <= 1'b0;
            end else if (sync) begin
               cnt_q     <= '0;
               level_q   <= 1'b0;
               tick_q    <= 1'b0;
               done_q    <= 1'b0;
            end else if (term) begin
               cnt_q     <= '0;
               level_q   <= ~level_q;
               tick_q    <= 1'b1;
               if (oneshot_q) begin
                  done_q <= 1'b1;
               end
            end else if (en[i] && !done_q) begin
               cnt_q     <= cnt_q + 1'b1;
               tick_q    <= 1'b0;
            end else begin
               tick_q    <= 1'b0;
            end
         end

         assign level[i] = level_q;
         assign tick[i]  = tick_q;
         assign done[i]  = done_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_bank
// Summary  : Directed bench for clk_div_bank (NUM_CH=4, CNT_W=8, H reset=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

   logic       clk;
   logic       reset;
   logic [3:0] en;
   logic       sync;
   logic       cfg_we;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_half;
   logic       cfg_oneshot;
   logic [3:0] level;
   logic [3:0] tick;
   logic [3:0] done;

   int tests;
   int failed;

   clk_div_bank #(
      .NUM_CH      (4),
      .CNT_W       (8),
      .DEFAULT_HALF(3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .sync       (sync),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_half   (cfg_half),
      .cfg_oneshot(cfg_oneshot),
      .level      (level),
      .tick       (tick),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] en;
      logic       we;
      logic [1:0] ch;
      logic [7:0] half;
      logic       os;
      logic [3:0] lvl;
      logic [3:0] tk;
      logic [3:0] dn;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic [3:0] e, input logic s, input logic w,
                       input logic [1:0] c, input logic [7:0] h,
                       input logic o, input logic r);
      en          = e;
      sync        = s;
      cfg_we      = w;
      cfg_ch      = c;
      cfg_half    = h;
      cfg_oneshot = o;
      reset       = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
   endtask

   initial begin
      int ticks;
      tests  = 0;
      failed = 0;

      // Cycle-by-cycle schedule after reset release (row k = edge k+1).
      for (int k = 0; k < 9; k++) vecs[k] = '{4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[3].lvl = 4'b0001; vecs[3].tk = 4'b0001;
      vecs[4].lvl = 4'b0001;
      vecs[5].lvl = 4'b0001;
      vecs[6].lvl = 4'b0001;
      vecs[7].tk  = 4'b0001;
      vecs[9]  = '{4'b0101, 1'b1, 2'd2, 8'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[10] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000};
      vecs[11] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 4'b0101, 4'b0000};
      vecs[12] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0101, 4'b0100, 4'b0000};
      vecs[13] = '{4'b0101, 1'b1, 2'd2, 8'd2, 1'b0, 4'b0001, 4'b0000, 4'b0000};
      vecs[14] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000};
      vecs[15] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0001, 4'b0000};
      vecs[16] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000};
      vecs[17] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000};
      vecs[18] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000};
      vecs[19] = '{4'b0101, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 4'b0101, 4'b0000};

      do_reset();
      chk("reset_level", level, 4'b0000);
      chk("reset_tick",  tick,  4'b0000);
      chk("reset_done",  done,  4'b0000);

      for (int k = 0; k < 20; k++) begin
         step(vecs[k].en, 1'b0, vecs[k].we, vecs[k].ch, vecs[k].half, vecs[k].os, 1'b0);
         chk($sformatf("vec%0d_level", k), level, vecs[k].lvl);
         chk($sformatf("vec%0d_tick",  k), tick,  vecs[k].tk);
         chk($sformatf("vec%0d_done",  k), done,  vecs[k].dn);
      end

      // One-shot on ch1, H=5: single tick on the 6th enabled edge, then frozen.
      do_reset();
      step(4'b0010, 1'b0, 1'b1, 2'd1, 8'd5, 1'b1, 1'b0);
      for (int rep = 0; rep < 2; rep++) begin
         for (int k = 1; k <= 6; k++) begin
            step(4'b0010, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
            chk($sformatf("shot%0d_e%0d_tick", rep, k), tick, (k == 6) ? 4'b0010 : 4'b0000);
            chk($sformatf("shot%0d_e%0d_done", rep, k), done, (k == 6) ? 4'b0010 : 4'b0000);
         end
         chk($sformatf("shot%0d_level", rep), level, 4'b0010);
         ticks = 0;
         for (int k = 0; k < 20; k++) begin
            step(4'b0010, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
            if (tick != 4'b0000) ticks++;
         end
         chk($sformatf("shot%0d_no_more_ticks", rep), 4'(ticks), 4'd0);
         chk($sformatf("shot%0d_held_level", rep), level, 4'b0010);
         chk($sformatf("shot%0d_held_done",  rep), done,  4'b0010);
         step(4'b0010, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
         chk($sformatf("shot%0d_sync_level", rep), level, 4'b0000);
         chk($sformatf("shot%0d_sync_done",  rep), done,  4'b0000);
         chk($sformatf("shot%0d_sync_tick",  rep), tick,  4'b0000);
      end

      // Pause: en[0] low for 5 edges once cnt=2 pushes the tick from edge 4 to 9.
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         step((k >= 3 && k <= 7) ? 4'b0000 : 4'b0001, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
         chk($sformatf("pause_e%0d_tick", k), tick, (k == 9) ? 4'b0001 : 4'b0000);
      end
      chk("pause_level", level, 4'b0001);

      // Write to ch0 on the edge where cnt==H: no tick, then 8 edges to the next.
      do_reset();
      for (int k = 1; k <= 3; k++) step(4'b0001, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b1, 2'd0, 8'd7, 1'b0, 1'b0);
      chk("wcoll_tick",  tick,  4'b0000);
      chk("wcoll_level", level, 4'b0000);
      for (int k = 1; k <= 8; k++) begin
         step(4'b0001, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
         chk($sformatf("wcoll_e%0d_tick", k), tick, (k == 8) ? 4'b0001 : 4'b0000);
      end
      chk("wcoll_after_level", level, 4'b0001);

      // Sync on the terminal edge of ch3: no tick, restart from zero.
      do_reset();
      for (int k = 1; k <= 3; k++) step(4'b1000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      step(4'b1000, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      chk("scoll_tick",  tick,  4'b0000);
      chk("scoll_level", level, 4'b0000);
      for (int k = 1; k <= 4; k++) begin
         step(4'b1000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
         chk($sformatf("scoll_e%0d_tick", k), tick, (k == 4) ? 4'b1000 : 4'b0000);
      end

      // Reset mid-operation: everything clears and H returns to 3 everywhere.
      do_reset();
      step(4'b1111, 1'b0, 1'b1, 2'd2, 8'd1, 1'b1, 1'b0);
      step(4'b1111, 1'b0, 1'b1, 2'd1, 8'd6, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step(4'b1111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
      chk("midrst_pre_done", done, 4'b0100);
      step(4'b1111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
      chk("midrst_level", level, 4'b0000);
      chk("midrst_tick",  tick,  4'b0000);
      chk("midrst_done",  done,  4'b0000);
      for (int k = 1; k <= 4; k++) begin
         step(4'b1111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
         chk($sformatf("midrst_e%0d_tick", k), tick, (k == 4) ? 4'b1111 : 4'b0000);
      end
      chk("midrst_level_after", level, 4'b1111);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, runtime-programmable clock-enable and square-wave generator. It is the parametrised successor of the fixed 1 Hz divider. Each of NUM_CH channels divides clk by a programmable half-period and supports a periodic or one-shot mode. Every channel provides a 50 % duty level output and a single-cycle tick strobe. The block sits next to the system clock and feeds timers, blinkers and display refresh logic, all of which stay in the clk domain.

## Interface
- NUM_CH, 4: number of independent channels (≥1).
- CNT_W, 28: counter and half-period register width.
- DEFAULT_HALF, 50000000: half-period terminal value loaded at reset. It must fit in CNT_W bits.
- CH_W, derived: max(1, clog2(NUM_CH)). This is a localparam, not settable.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- en  in  NUM_CH  per-channel count enable.
- sync  in  1  phase-align pulse: restarts all channels together.
- cfg_we  in  1  configuration write strobe (one cycle per write).
- cfg_ch  in  CH_W  target channel of the write.
- cfg_half  in  CNT_W  new terminal value H for the channel.
- cfg_oneshot  in  1  new mode: 1 = one-shot, 0 = periodic.
- level  out  NUM_CH  per-channel square wave / one-shot level.
- tick  out  NUM_CH  per-channel one-cycle strobe at each level toggle.
- done  out  NUM_CH  per-channel one-shot completion flag (sticky).

## Operation
Per-channel state:
- H[i] (CNT_W bits)
- mode[i]
- cnt[i] (CNT_W bits)
- level[i]
- tick[i]
- done[i]

Terminal event for channel i occurs when en[i]=1, cnt[i]==H[i] and done[i]=0.

Priority per channel, highest first. Exactly one rule applies per edge:
1. reset:
   - H ← DEFAULT_HALF, mode ← periodic.
   - cnt, level, tick, done ← 0.
2. Config write when cfg_we=1 and cfg_ch==i:
   - H ← cfg_half, mode ← cfg_oneshot.
   - cnt, level, tick, done ← 0.
   - A terminal event in the same cycle is discarded.
3. sync=1:
   - cnt, level, tick, done ← 0.
   - H and mode are retained.
4. Terminal event:
   - cnt ← 0, level ← ~level, tick ← 1.
   - In one-shot mode, done ← 1 as well.
5. en[i]=1 and done[i]=0: cnt ← cnt+1, tick ← 0.
6. Otherwise: cnt and level hold, tick ← 0.

Other rules:
- A write with cfg_ch ≥ NUM_CH is ignored with no side effects. This case is only reachable when NUM_CH is not a power of two.
- Writes to different channels are independent. A write to channel j does not disturb channel i≠j, and there is at most one write per cycle.
- One-shot sequence: level rises after H+1 enabled cycles with a single tick, then done=1. The channel then freezes (cnt=0, level=1, tick=0) until the next write, sync or reset.
- cnt never exceeds H. Because increments stop at H, there is no wrap-around arithmetic.
- H=0 is legal. With en held high, level toggles every cycle and tick stays high continuously in periodic mode.
- No combinational path from inputs to outputs: level, tick and done are registers.

## Timing
- Reset values: level=0, tick=0, done=0 on all channels. H=DEFAULT_HALF, periodic mode.
- Periodic mode with en continuously high:
  - half-period is H+1 cycles; full period is 2(H+1) cycles.
  - tick asserts for exactly 1 cycle, every H+1 cycles.
  - With the defaults, the first tick and toggle follow 50,000,001 enabled cycles after reset release.
- tick and the level toggle appear together, in the cycle after the edge that sampled cnt==H.
- en low freezes phase: the count resumes from its held value when en returns. Pausing for k cycles delays the next tick by exactly k cycles.
- Write latency: 1 cycle. The new H applies to the count starting at the next edge, so the first tick follows H+1 enabled cycles after the write edge.
- sync takes effect on the same edge for all channels. After sync, channels with equal H and continuous en toggle in lockstep.
- Reset asserted mid-count aborts immediately with no residual tick.

## Test plan
Bench parameters: NUM_CH=4, CNT_W=8, DEFAULT_HALF=3.
- Release reset, en=4'b0001 -> level[0] toggles every 4 cycles (period 8). tick[0] pulses 1 cycle every 4 cycles. Channels 1–3 stay at level=0, tick=0.
- Write ch2, H=0 periodic, en[2]=1 -> tick[2] held high and level[2] toggles every cycle. Then write ch2 H=2 -> tick every 3 cycles, starting 3 cycles after the write, with level restarting from 0.
- Write ch1, H=5 one-shot, en[1]=1 -> after 6 cycles there is a single tick, level[1]=1 and done[1]=1. Hold 20 more cycles with no further ticks. sync -> done[1]=0, level[1]=0, and the shot repeats.
- Ch0 at H=3: drop en[0] for 5 cycles when cnt=2 -> the next tick is delayed by exactly 5 cycles relative to the uninterrupted schedule.
- Collision: assert a write to ch0 (H=7) in the same cycle ch0 reaches cnt==H -> no tick, level[0]=0, next tick 8 cycles later. sync coincident with a terminal event on ch3 -> no tick on ch3.
- Reset pulse mid-operation with all channels running -> next cycle all level, tick and done are 0, and H reverts to 3 on every channel.
